// File: rtl/nic8_pkg.sv
// Shared definitions for the nic8 fetch/control pair.
// State encoding, instruction-register field helpers and opcode constants.
package nic8_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    localparam logic [2:0] DEST_PC = 3'd7;
    localparam logic [2:0] SRC_ROM = 3'd1;
    localparam logic [2:0] SRC_E   = 3'd6;
    localparam logic [7:0] NOP     = 8'h00;

    function automatic logic [2:0] ir_dest(input logic [7:0] ir);
        return ir[6:4];
    endfunction

    function automatic logic [2:0] ir_src(input logic [7:0] ir);
        return ir[2:0];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ROM and control-decoder signals seen by the fetch unit.
// master = fetch unit side, slave = ROM/control side.
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] romAddr;
    logic [7:0]      romData;
    logic [7:0]      dataBus;
    logic            assertRomBar;
    logic            doJumpBar;
    logic [7:0]      ir;

    modport master (
        output romAddr,
        output ir,
        input  romData,
        input  dataBus,
        input  assertRomBar,
        input  doJumpBar
    );

    modport slave (
        input  romAddr,
        input  ir,
        output romData,
        output dataBus,
        output assertRomBar,
        output doJumpBar
    );
endinterface

// File: rtl/fetch_unit_rom_wait_counter.sv
// Wait-state counter for one ROM access: counts 0..ROM_WAIT.
// done is high on the last cycle of the access; restart begins a new one.
module rom_wait_counter #(
    parameter int ROM_WAIT = 0
) (
    input  logic clk,
    input  logic resetBar,
    input  logic restart,
    input  logic en,
    output logic done
);
    logic [2:0] cnt;

    assign done = (cnt == 3'(ROM_WAIT));

    always_ff @(posedge clk) begin
        if (!resetBar || restart) begin
            cnt <= 3'd0;
        end else if (en && !done) begin
            cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Program counter / instruction register sequencer with ROM wait states.
// Optional self-jump halt detection when HALT_DETECT_EN is defined.
module fetch_unit
    import nic8_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int ROM_WAIT = 0
) (
    input  logic            clk,
    input  logic            resetBar,
    fetch_unit_if.master    bus,
    output logic [PC_W-1:0] pc,
    output logic            execStrobe,
    output logic            halted
);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [PC_W-1:0] target;
    logic            restart, done, strobe;

`ifdef HALT_DETECT_EN
    logic            halt_q, halt_d;
    logic [PC_W-1:0] ir_addr_q, ir_addr_d;
`else
    logic            halt_q;
    assign halt_q = 1'b0;
`endif

    assign target      = PC_W'(bus.dataBus);
    assign bus.romAddr = pc_q;
    assign bus.ir      = ir_q;
    assign pc          = pc_q;
    assign execStrobe  = strobe;
    assign halted      = halt_q;

    rom_wait_counter #(
        .ROM_WAIT(ROM_WAIT)
    ) u_wait (
        .clk     (clk),
        .resetBar(resetBar),
        .restart (restart),
        .en      (!halt_q),
        .done    (done)
    );

    always_ff @(posedge clk) begin
        if (!resetBar) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef HALT_DETECT_EN
    always_ff @(posedge clk) begin
        if (!resetBar) begin
            halt_q    <= 1'b0;
            ir_addr_q <= '0;
        end else begin
            halt_q    <= halt_d;
            ir_addr_q <= ir_addr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        restart = 1'b0;
        strobe  = 1'b0;
`ifdef HALT_DETECT_EN
        halt_d    = halt_q;
        ir_addr_d = ir_addr_q;
`endif
        if (!halt_q) begin
            unique case (state_q)
                S_FETCH: begin
                    if (done) begin
                        ir_d    = bus.romData;
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_EXEC;
                        restart = 1'b1;
`ifdef HALT_DETECT_EN
                        ir_addr_d = pc_q;
`endif
                    end
                end
                S_EXEC: begin
                    // Register-source instructions finish at once; immediates wait out the ROM.
                    if (bus.assertRomBar || done) begin
                        strobe  = 1'b1;
                        restart = 1'b1;
                        state_d = S_FETCH;
                        if (!bus.doJumpBar) begin
                            pc_d = target;
                        end else if (!bus.assertRomBar) begin
                            pc_d = pc_q + PC_W'(1);
                        end
`ifdef HALT_DETECT_EN
                        if (!bus.doJumpBar && target == ir_addr_q) begin
                            halt_d = 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Two fetch units (ROM_WAIT 0 and 3) run the same program against an
// instruction-level model that predicts per-cycle romAddr, ir, pc and strobe.
module tb_fetch_unit;
    import nic8_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic [7:0] rom     [256];
    logic [7:0] bus_tab [256];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W = (g == 0) ? 0 : 3;

        fetch_unit_if #(.PC_W(8)) bus ();
        logic [7:0] pc_o;
        logic       strobe_o, halted_o;

        fetch_unit #(
            .PC_W    (8),
            .ROM_WAIT(W)
        ) dut (
            .clk       (clk),
            .resetBar  (rst_n[g]),
            .bus       (bus.master),
            .pc        (pc_o),
            .execStrobe(strobe_o),
            .halted    (halted_o)
        );

        // ROM returns garbage until the address has been stable W cycles
        logic [7:0] prev_addr = 8'h00;
        int         age = 0;
        always @(posedge clk) begin
            age       <= (bus.romAddr == prev_addr) ? age + 1 : 1;
            prev_addr <= bus.romAddr;
        end
        assign bus.romData = (W == 0 || (bus.romAddr == prev_addr && age >= W))
                             ? rom[bus.romAddr] : 8'hEE;
        assign bus.assertRomBar = !(ir_src(bus.ir) == SRC_ROM);
        assign bus.doJumpBar    = !(ir_dest(bus.ir) == DEST_PC);

        bit         active = 0;
        bit         mhalt = 0;
        bit         imm, jmp;
        int         k = 0;
        int         len = 2;
        logic [7:0] mpc = 8'h00;
        logic [7:0] ia = 8'h00;
        logic [7:0] instr = 8'h00;
        logic [7:0] prev_ir = 8'h00;

        always @(negedge clk) begin
            if (!rst_n[g]) begin
                active = 0;
            end else begin
                if (!active) begin
                    active  = 1;
                    k       = 0;
                    mpc     = 8'h00;
                    mhalt   = 0;
                    prev_ir = 8'h00;
                    check($sformatf("l%0d_rst_pc", g), pc_o, 8'h00);
                    check($sformatf("l%0d_rst_ir", g), bus.ir, 8'h00);
                end
                if (mhalt) begin
                    check($sformatf("l%0d_halt_flag", g), halted_o, 1);
                    check($sformatf("l%0d_halt_pc", g), pc_o, mpc);
                    check($sformatf("l%0d_halt_strobe", g), strobe_o, 0);
                end else begin
                    if (k == 0) begin
                        ia    = mpc;
                        instr = rom[mpc];
                        imm   = (instr[2:0] == 3'd1);
                        jmp   = (instr[6:4] == 3'd7);
                        len   = imm ? 2 + 2 * W : 2 + W;
                        bus.dataBus = bus_tab[mpc];
                    end
                    check($sformatf("l%0d_strobe", g), strobe_o, (k == len - 1));
                    check($sformatf("l%0d_halted", g), halted_o, 0);
                    if (k < 1 + W) begin
                        check($sformatf("l%0d_faddr", g), bus.romAddr, ia);
                        check($sformatf("l%0d_ir_hold", g), bus.ir, prev_ir);
                    end else begin
                        check($sformatf("l%0d_xaddr", g), bus.romAddr, 8'(ia + 8'd1));
                        check($sformatf("l%0d_ir", g), bus.ir, instr);
                        check($sformatf("l%0d_pc", g), pc_o, 8'(ia + 8'd1));
                    end
                    if (k == len - 1) begin
                        if (jmp) begin
                            mpc = bus_tab[ia];
`ifdef HALT_DETECT_EN
                            if (mpc == ia) mhalt = 1;
`endif
                        end else begin
                            mpc = 8'(ia + 8'd1 + {7'd0, imm});
                        end
                        prev_ir = instr;
                        k = 0;
                    end else begin
                        k++;
                    end
                end
            end
        end
    end

    task automatic reset_all();
        @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
    endtask

    task automatic release_all();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
    endtask

    initial begin
        bit hit;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i]     = 8'h20;
            bus_tab[i] = 8'h00;
        end

        // directed loop: nop, imm, jump 0x40, jump 0xFF, imm across wrap
        rom[8'h00] = 8'h20;
        rom[8'h01] = 8'h21;
        rom[8'h02] = 8'h5A;
        rom[8'h03] = 8'h70;
        bus_tab[8'h03] = 8'h40;
        rom[8'h40] = 8'h70;
        bus_tab[8'h40] = 8'hFF;
        rom[8'hFF] = 8'h21;
        reset_all();
        release_all();
        repeat (120) @(posedge clk);

        // reset lane 1 while an immediate EXEC is waiting on the ROM
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (lane[1].active && !lane[1].mhalt && lane[1].imm &&
                lane[1].k >= 4 && lane[1].k < 7) hit = 1;
        end
        check("midwait_reached", hit, 1);
        rst_n[1] = 1'b0;
        @(posedge clk);
        #2;
        rst_n[1] = 1'b1;
        repeat (60) @(posedge clk);

        // randomized program and jump targets
        reset_all();
        for (int i = 0; i < 256; i++) begin
            rom[i]     = 8'($urandom);
            bus_tab[i] = 8'($urandom);
        end
        release_all();
        repeat (3000) @(posedge clk);

        // self-jump at address 5
        reset_all();
        for (int i = 0; i < 256; i++) begin
            rom[i]     = 8'h20;
            bus_tab[i] = 8'h00;
        end
        rom[8'h00] = 8'h70;
        bus_tab[8'h00] = 8'h05;
        rom[8'h05] = 8'h70;
        bus_tab[8'h05] = 8'h05;
        release_all();
        repeat (60) @(posedge clk);
`ifdef HALT_DETECT_EN
        #2;
        check("halt_l0_pc", lane[0].pc_o, 8'h05);
        check("halt_l1_flag", lane[1].halted_o, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
